// File: rtl/cum_hist_percentile.sv
// Cumulative histogram builder with percentile threshold search.
// Streams N = 2^BIN_BITS source bins out of a synchronous-read RAM, writes
// the saturating running sum to a cumulative RAM, finds the first bins whose
// cumulative count reaches the low/high targets, and tracks the largest bin.
// Optional feature macro: CUMHIST_CLEAR_EN -- when defined, each source bin
// is cleared through oClrWE/oAddrClr in the same cycle as its cumulative write.
//
// Handshake: iStart is a level sampled only in IDLE; one sample launches one
// scan. oBusy is high from PRIME through DONE, oDone pulses for one cycle when
// the result registers update. The cumulative RAM takes a write on every
// cycle oWE is high; there is no back-pressure.
module cum_hist_percentile #(
   parameter int BIN_BITS  = 8,
   parameter int WORD_SIZE = 20
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic                 iStart,
   input  logic [WORD_SIZE-1:0] iPctLo,
   input  logic [WORD_SIZE-1:0] iPctHi,
   output logic [BIN_BITS-1:0]  oAddrInHist,
   input  logic [WORD_SIZE-1:0] iQInHist,
   output logic                 oWE,
   output logic [BIN_BITS-1:0]  oAddrOutCumH,
   output logic [WORD_SIZE-1:0] oDataOutCumH,
   output logic                 oClrWE,
   output logic [BIN_BITS-1:0]  oAddrClr,
   output logic [BIN_BITS-1:0]  oThreshLo,
   output logic [BIN_BITS-1:0]  oThreshHi,
   output logic [WORD_SIZE-1:0] oMaxValue,
   output logic [BIN_BITS-1:0]  oMaxBin,
   output logic [WORD_SIZE-1:0] oTotal,
   output logic                 oBusy,
   output logic                 oDone,
   output logic [1:0]           oDbgState
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [BIN_BITS-1:0]  LAST_BIN = '1;
   localparam logic [WORD_SIZE-1:0] SAT_MAX  = '1;

   state_t                 state_q;
   logic [BIN_BITS-1:0]    addr_q;
   logic [BIN_BITS-1:0]    k_q;
   logic [WORD_SIZE-1:0]   acc_q;
   logic [WORD_SIZE-1:0]   pct_lo_q;
   logic [WORD_SIZE-1:0]   pct_hi_q;
   logic                   found_lo_q;
   logic                   found_hi_q;
   logic [BIN_BITS-1:0]    th_lo_q;
   logic [BIN_BITS-1:0]    th_hi_q;
   logic [WORD_SIZE-1:0]   max_val_q;
   logic [BIN_BITS-1:0]    max_bin_q;

   logic                   we_q;
   logic [BIN_BITS-1:0]    wa_q;
   logic [WORD_SIZE-1:0]   wd_q;
   logic [BIN_BITS-1:0]    res_lo_q;
   logic [BIN_BITS-1:0]    res_hi_q;
   logic [WORD_SIZE-1:0]   res_max_q;
   logic [BIN_BITS-1:0]    res_mbin_q;
   logic [WORD_SIZE-1:0]   res_tot_q;
   logic                   busy_q;
   logic                   done_q;

   logic [WORD_SIZE:0]     sum_w;
   logic [WORD_SIZE-1:0]   acc_d;
   logic                   hit_lo_d;
   logic                   hit_hi_d;
   logic                   max_upd_d;

   // Saturating accumulate of the current bin plus first-hit and new-max detection.
   always_comb begin
      sum_w     = {1'b0, acc_q} + {1'b0, iQInHist};
      acc_d     = sum_w[WORD_SIZE] ? SAT_MAX : sum_w[WORD_SIZE-1:0];
      hit_lo_d  = !found_lo_q && (acc_d >= pct_lo_q);
      hit_hi_d  = !found_hi_q && (acc_d >= pct_hi_q);
      max_upd_d = (iQInHist > max_val_q);
   end

   // Scan FSM with all datapath registers and registered outputs.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         pct_lo_q   <= '0;
         pct_hi_q   <= '0;
         found_lo_q <= 1'b0;
         found_hi_q <= 1'b0;
         th_lo_q    <= '0;
         th_hi_q    <= '0;
         max_val_q  <= '0;
         max_bin_q  <= '0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
         res_lo_q   <= '0;
         res_hi_q   <= '0;
         res_max_q  <= '0;
         res_mbin_q <= '0;
         res_tot_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (iStart) begin
                  state_q    <= PRIME;
                  addr_q     <= '0;
                  pct_lo_q   <= iPctLo;
                  pct_hi_q   <= iPctHi;
                  acc_q      <= '0;
                  found_lo_q <= 1'b0;
                  found_hi_q <= 1'b0;
                  th_lo_q    <= '0;
                  th_hi_q    <= '0;
                  max_val_q  <= '0;
                  max_bin_q  <= '0;
                  busy_q     <= 1'b1;
               end
            end
            PRIME: begin
               // Bin 0 data arrives next cycle; address 1 is already in flight.
               addr_q  <= addr_q + 1'b1;
               k_q     <= '0;
               state_q <= SCAN;
            end
            SCAN: begin
               addr_q <= addr_q + 1'b1;
               k_q    <= k_q + 1'b1;
               acc_q  <= acc_d;
               we_q   <= 1'b1;
               wa_q   <= k_q;
               wd_q   <= acc_d;
               if (hit_lo_d) begin
                  found_lo_q <= 1'b1;
                  th_lo_q    <= k_q;
               end
               if (hit_hi_d) begin
                  found_hi_q <= 1'b1;
                  th_hi_q    <= k_q;
               end
               if (max_upd_d) begin
                  max_val_q <= iQInHist;
                  max_bin_q <= k_q;
               end
               if (k_q == LAST_BIN) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               // Unreached targets fall back to the last bin.
               res_lo_q   <= found_lo_q ? th_lo_q : LAST_BIN;
               res_hi_q   <= found_hi_q ? th_hi_q : LAST_BIN;
               res_max_q  <= max_val_q;
               res_mbin_q <= max_bin_q;
               res_tot_q  <= acc_q;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CUMHIST_CLEAR_EN
   logic                clr_we_q;
   logic [BIN_BITS-1:0] clr_addr_q;

   // Clear the source bin alongside its cumulative write, ready for the next frame.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         clr_we_q   <= 1'b0;
         clr_addr_q <= '0;
      end else begin
         clr_we_q <= (state_q == SCAN);
         if (state_q == SCAN) begin
            clr_addr_q <= k_q;
         end
      end
   end

   assign oClrWE   = clr_we_q;
   assign oAddrClr = clr_addr_q;
`else
   assign oClrWE   = 1'b0;
   assign oAddrClr = '0;
`endif

   assign oAddrInHist  = addr_q;
   assign oWE          = we_q;
   assign oAddrOutCumH = wa_q;
   assign oDataOutCumH = wd_q;
   assign oThreshLo    = res_lo_q;
   assign oThreshHi    = res_hi_q;
   assign oMaxValue    = res_max_q;
   assign oMaxBin      = res_mbin_q;
   assign oTotal       = res_tot_q;
   assign oBusy        = busy_q;
   assign oDone        = done_q;
   assign oDbgState    = state_q;

endmodule

// File: tb/tb_cum_hist_percentile.sv
// Bench for cum_hist_percentile: source and cumulative RAM models, a table of
// directed histogram frames with hand-computed results, and hand-written
// sequences for mid-scan start, mid-scan reset and back-to-back scans.
module tb_cum_hist_percentile;

   localparam int BB = 8;
   localparam int W  = 20;
   localparam int N  = 256;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  pct_lo = '0;
   logic [W-1:0]  pct_hi = '0;
   logic [BB-1:0] addr_in;
   logic [W-1:0]  q_in;
   logic          we;
   logic [BB-1:0] addr_out;
   logic [W-1:0]  data_out;
   logic          clr_we;
   logic [BB-1:0] addr_clr;
   logic [BB-1:0] th_lo;
   logic [BB-1:0] th_hi;
   logic [W-1:0]  max_val;
   logic [BB-1:0] max_bin;
   logic [W-1:0]  total_o;
   logic          busy;
   logic          done;
   logic [1:0]    dbg_state;

   cum_hist_percentile #(.BIN_BITS(BB), .WORD_SIZE(W)) dut (
      .iClk         (clk),
      .iRst_n       (rst_n),
      .iStart       (start),
      .iPctLo       (pct_lo),
      .iPctHi       (pct_hi),
      .oAddrInHist  (addr_in),
      .iQInHist     (q_in),
      .oWE          (we),
      .oAddrOutCumH (addr_out),
      .oDataOutCumH (data_out),
      .oClrWE       (clr_we),
      .oAddrClr     (addr_clr),
      .oThreshLo    (th_lo),
      .oThreshHi    (th_hi),
      .oMaxValue    (max_val),
      .oMaxBin      (max_bin),
      .oTotal       (total_o),
      .oBusy        (busy),
      .oDone        (done),
      .oDbgState    (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // RAM models: synchronous-read source RAM with fill and clear ports, cumulative RAM.
   logic [W-1:0]  src [N];
   logic [W-1:0]  cum [N];
   logic          fill_we = 1'b0;
   logic [BB-1:0] fill_addr = '0;
   logic [W-1:0]  fill_data = '0;

   always @(posedge clk) begin
      q_in <= src[addr_in];
      if (fill_we) src[fill_addr] <= fill_data;
      else if (clr_we) src[addr_clr] <= '0;
      if (we) cum[addr_out] <= data_out;
   end

   // Event counters sampled mid-cycle.
   int we_total = 0;
   int done_total = 0;
   int clr_total = 0;
   always @(negedge clk) begin
      if (we) we_total++;
      if (done) done_total++;
      if (clr_we) clr_total++;
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // kind 0: every bin v; 1: bin b = v, others 0; 2: bin i = i; 3: bins 10,20 = 7, others 1.
   task automatic fill(input int kind, input logic [W-1:0] v, input int b);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         fill_we   = 1'b1;
         fill_addr = i[BB-1:0];
         case (kind)
            0: fill_data = v;
            1: fill_data = (i == b) ? v : '0;
            2: fill_data = i[W-1:0];
            default: fill_data = (i == 10 || i == 20) ? 20'd7 : 20'd1;
         endcase
      end
      @(negedge clk);
      fill_we = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_we"}, 32'(we), 0);
      chk({tag, "_state"}, 32'(dbg_state), 0);
      chk({tag, "_addr"}, 32'(addr_in), 0);
      chk({tag, "_thlo"}, 32'(th_lo), 0);
      chk({tag, "_thhi"}, 32'(th_hi), 0);
      chk({tag, "_max"}, 32'(max_val), 0);
      chk({tag, "_mbin"}, 32'(max_bin), 0);
      chk({tag, "_tot"}, 32'(total_o), 0);
   endtask

   // One scan over a fixed 300-cycle window; c counts clocks after the iStart sample edge.
   task automatic scan(input int poke_at, input int rst_at,
                       output int lat, output int ndone, output int nwe,
                       output int nwe_post, output int clr_n,
                       output logic [BB-1:0] hold_lo,
                       output logic busy_mid, output logic busy_end);
      int we0, d0, c0, we_rst;
      we0 = we_total; d0 = done_total; c0 = clr_total;
      we_rst = 0; lat = -1; hold_lo = '0; busy_mid = 1'b0; busy_end = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (c == 60) hold_lo = th_lo;
         if (c == 100) busy_mid = busy;
         if (c == 260) busy_end = busy;
         if (done && lat < 0) lat = c;
         start = (c == poke_at);
         if (rst_at >= 0 && c == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_zero_outputs("midrst");
         end
         if (rst_at >= 0 && c == rst_at + 1) we_rst = we_total;
         if (rst_at >= 0 && c == rst_at + 2) rst_n = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      #1;
      ndone = done_total - d0;
      nwe = we_total - we0;
      nwe_post = (rst_at >= 0) ? (we_total - we_rst) : 0;
      clr_n = clr_total - c0;
   endtask

   task automatic check_src_cleared(input string tag);
`ifdef CUMHIST_CLEAR_EN
      int nz;
      nz = 0;
      for (int i = 0; i < N; i++) if (src[i] != '0) nz++;
      chk({tag, "_src_nonzero"}, nz, 0);
`else
      chk({tag, "_src_kept"}, 32'(src[5]), 32'(src[5] == '0 ? 0 : src[5]));
`endif
   endtask

   typedef struct {
      int            kind;
      logic [W-1:0]  v;
      int            b;
      logic [W-1:0]  lo;
      logic [W-1:0]  hi;
      logic [BB-1:0] e_lo;
      logic [BB-1:0] e_hi;
      logic [W-1:0]  e_tot;
      logic [W-1:0]  e_max;
      logic [BB-1:0] e_mbin;
      int            cbin;
      logic [W-1:0]  cval;
   } vec_t;

   vec_t vt [7];

   initial begin
      int lat, ndone, nwe, nwe_post, clr_n, t1, t2;
      logic [BB-1:0] hold_lo, prev_lo;
      logic busy_mid, busy_end;

      vt[0] = '{0, 20'd1500,   0, 20'd192000, 20'd288000,  8'd127, 8'd191, 20'd384000,  20'd1500,   8'd0,   0,   20'd1500};
      vt[1] = '{1, 20'd384000, 40, 20'd192000, 20'd288000, 8'd40,  8'd40,  20'd384000,  20'd384000, 8'd40,  39,  20'd0};
      vt[2] = '{1, 20'd384000, 40, 20'd384000, 20'd384000, 8'd40,  8'd40,  20'd384000,  20'd384000, 8'd40,  40,  20'd384000};
      vt[3] = '{0, 20'd8192,   0, 20'd192000, 20'd1048575,   8'd23,  8'd127, 20'd1048575, 20'd8192,   8'd0,   126, 20'd1040384};
      vt[4] = '{0, 20'd0,      0, 20'd1,      20'd1,       8'd255, 8'd255, 20'd0,       20'd0,      8'd0,   128, 20'd0};
      vt[5] = '{2, 20'd0,      0, 20'd0,      20'd32640,   8'd0,   8'd255, 20'd32640,   20'd255,    8'd255, 9,   20'd45};
      vt[6] = '{3, 20'd0,      0, 20'd0,      20'd100,     8'd0,   8'd87,  20'd268,     20'd7,      8'd10,  20,  20'd33};

      // Reset state.
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      prev_lo = '0;

      // Table-driven frames.
      for (int i = 0; i < 7; i++) begin
         fill(vt[i].kind, vt[i].v, vt[i].b);
         pct_lo = vt[i].lo;
         pct_hi = vt[i].hi;
         scan(-1, -1, lat, ndone, nwe, nwe_post, clr_n, hold_lo, busy_mid, busy_end);
         $display("vector %0d: lo=%0d hi=%0d tot=%0d max=%0d@%0d", i, th_lo, th_hi, total_o, max_val, max_bin);
         chk("latency", lat, 258);
         chk("done_count", ndone, 1);
         chk("we_count", nwe, 256);
         chk("busy_mid", 32'(busy_mid), 1);
         chk("busy_end", 32'(busy_end), 0);
         chk("hold_prev_lo", 32'(hold_lo), 32'(prev_lo));
         chk("thresh_lo", 32'(th_lo), 32'(vt[i].e_lo));
         chk("thresh_hi", 32'(th_hi), 32'(vt[i].e_hi));
         chk("total", 32'(total_o), 32'(vt[i].e_tot));
         chk("max_value", 32'(max_val), 32'(vt[i].e_max));
         chk("max_bin", 32'(max_bin), 32'(vt[i].e_mbin));
         chk("cum_bin", 32'(cum[vt[i].cbin]), 32'(vt[i].cval));
         chk("cum_last", 32'(cum[N-1]), 32'(vt[i].e_tot));
`ifdef CUMHIST_CLEAR_EN
         chk("clr_count", clr_n, 256);
         check_src_cleared("frame");
`endif
         prev_lo = vt[i].e_lo;
      end

      // iStart pulsed mid-scan is ignored.
      fill(0, 20'd1500, 0);
      pct_lo = 20'd192000;
      pct_hi = 20'd288000;
      scan(50, -1, lat, ndone, nwe, nwe_post, clr_n, hold_lo, busy_mid, busy_end);
      chk("poke_latency", lat, 258);
      chk("poke_done_count", ndone, 1);
      chk("poke_we_count", nwe, 256);
      chk("poke_thresh_lo", 32'(th_lo), 127);
      chk("poke_thresh_hi", 32'(th_hi), 191);

      // Reset mid-scan aborts: no done, no further writes, results zero.
      fill(0, 20'd1500, 0);
      scan(-1, 100, lat, ndone, nwe, nwe_post, clr_n, hold_lo, busy_mid, busy_end);
      chk("abort_done_count", ndone, 0);
      chk("abort_writes_after_reset", nwe_post, 0);
      chk("abort_thresh_lo", 32'(th_lo), 0);
      chk("abort_total", 32'(total_o), 0);

      // Next start completes normally.
      fill(0, 20'd1500, 0);
      scan(-1, -1, lat, ndone, nwe, nwe_post, clr_n, hold_lo, busy_mid, busy_end);
      chk("rerun_latency", lat, 258);
      chk("rerun_thresh_lo", 32'(th_lo), 127);
      chk("rerun_thresh_hi", 32'(th_hi), 191);
      chk("rerun_total", 32'(total_o), 384000);
      chk("rerun_max", 32'(max_val), 1500);
      chk("rerun_mbin", 32'(max_bin), 0);
`ifdef CUMHIST_CLEAR_EN
      chk("rerun_clr_count", clr_n, 256);
      check_src_cleared("rerun");
`endif

      // iStart held high: back-to-back scans, one IDLE cycle between.
      fill(0, 20'd1500, 0);
      t1 = -1;
      t2 = -1;
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (done) begin
            if (t1 < 0) t1 = c;
            else if (t2 < 0) t2 = c;
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (300) @(negedge clk);
      chk("b2b_gap", t2 - t1, 259);
      chk("b2b_idle_after", 32'(busy), 0);

`ifndef CUMHIST_CLEAR_EN
      chk("clr_never", clr_total, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
